// File: rtl/xy_rr_scheduler.sv
// xy_rr_scheduler: per-router scheduler for the simple_mesh_xy switch.
// Computes the XY-routed output port of every input FIFO head, round-robin arbitrates a
// single input->output pair at a time, and releases a stalled grant after MAX_WAIT cycles.
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   vld_input_i    per-input head-flit valid
//   dst_x_i/dst_y_i packed head destination coordinates, port p at [p*COORD_W +: COORD_W]
//   full_i         per-output back-pressure
//   wr_en_i        per-output write strobes
//   mux_in_sel_o   granted input port
//   mux_out_sel_o  routed output port of the granted input
//   sel_vld_o      select pair valid
//   timeout_o      one-cycle pulse when a grant is released by timeout
module xy_rr_scheduler #(
  parameter int unsigned PORT_N   = 5,
  parameter int unsigned COORD_W  = 4,
  parameter int unsigned ROUTER_X = 0,
  parameter int unsigned ROUTER_Y = 0,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [PORT_N-1:0]           vld_input_i,
  input  logic [PORT_N*COORD_W-1:0]   dst_x_i,
  input  logic [PORT_N*COORD_W-1:0]   dst_y_i,
  input  logic [PORT_N-1:0]           full_i,
  input  logic [PORT_N-1:0]           wr_en_i,
  output logic [$clog2(PORT_N)-1:0]   mux_in_sel_o,
  output logic [$clog2(PORT_N)-1:0]   mux_out_sel_o,
  output logic                        sel_vld_o,
  output logic                        timeout_o
);

  localparam int unsigned SelW = $clog2(PORT_N);
  localparam int unsigned CntW = $clog2(MAX_WAIT);

  localparam logic [SelW-1:0] PortLocal = SelW'(0);
  localparam logic [SelW-1:0] PortNorth = SelW'(1);
  localparam logic [SelW-1:0] PortEast  = SelW'(2);
  localparam logic [SelW-1:0] PortSouth = SelW'(3);
  localparam logic [SelW-1:0] PortWest  = SelW'(4);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [SelW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SelW-1:0] in_sel_q, in_sel_d;
  logic [SelW-1:0] out_sel_q, out_sel_d;
  logic            sel_vld_q, sel_vld_d;
  logic            timeout_q, timeout_d;

  logic [SelW-1:0] route [PORT_N];
  logic [PORT_N-1:0] req;
  logic            gnt_found;
  logic [SelW-1:0] gnt_idx;
  logic [SelW-1:0] ptr_next;
  logic            xfer, hold, expire;

  // XY routing: resolve X first, then Y.
  always_comb begin
    for (int p = 0; p < int'(PORT_N); p++) begin
      if (dst_x_i[p*COORD_W +: COORD_W] > COORD_W'(ROUTER_X)) begin
        route[p] = PortEast;
      end else if (dst_x_i[p*COORD_W +: COORD_W] < COORD_W'(ROUTER_X)) begin
        route[p] = PortWest;
      end else if (dst_y_i[p*COORD_W +: COORD_W] > COORD_W'(ROUTER_Y)) begin
        route[p] = PortNorth;
      end else if (dst_y_i[p*COORD_W +: COORD_W] < COORD_W'(ROUTER_Y)) begin
        route[p] = PortSouth;
      end else begin
        route[p] = PortLocal;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < int'(PORT_N); p++) begin
      req[p] = vld_input_i[p] & ~full_i[route[p]];
    end
  end

  // Round-robin scan starting at rr_ptr_q, wrapping mod PORT_N.
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < PORT_N; k++) begin
      cand = (32'(rr_ptr_q) + k) % PORT_N;
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = SelW'(cand);
      end
    end
  end

  assign ptr_next = (in_sel_q == SelW'(PORT_N - 1)) ? '0 : in_sel_q + SelW'(1);
  assign xfer     = wr_en_i[out_sel_q];
  assign hold     = vld_input_i[in_sel_q];
  assign expire   = (wait_cnt_q == CntW'(MAX_WAIT - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    in_sel_d   = in_sel_q;
    out_sel_d  = out_sel_q;
    sel_vld_d  = sel_vld_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          in_sel_d   = gnt_idx;
          out_sel_d  = route[gnt_idx];
          sel_vld_d  = 1'b1;
          wait_cnt_d = '0;
          state_d    = StBusy;
        end else begin
          sel_vld_d = 1'b0;
        end
      end
      StBusy: begin
        // Transfer beats an abandoned head, which beats the timeout.
        if (xfer || !hold || expire) begin
          state_d   = StIdle;
          sel_vld_d = 1'b0;
          rr_ptr_d  = ptr_next;
          timeout_d = !xfer && hold;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        sel_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      in_sel_q   <= '0;
      out_sel_q  <= '0;
      sel_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      in_sel_q   <= in_sel_d;
      out_sel_q  <= out_sel_d;
      sel_vld_q  <= sel_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mux_in_sel_o  = in_sel_q;
  assign mux_out_sel_o = out_sel_q;
  assign sel_vld_o     = sel_vld_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_xy_rr_scheduler.sv
module tb_xy_rr_scheduler;

  localparam int N  = 5;
  localparam int CW = 4;
  localparam int RX = 1;
  localparam int RY = 1;
  localparam int MW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    vld, full, wr;
  logic [N*CW-1:0] dx, dy;
  logic [2:0]      in_sel, out_sel;
  logic            sel_vld, tmo;

  always #5 clk = ~clk;

  xy_rr_scheduler #(
    .PORT_N   (N),
    .COORD_W  (CW),
    .ROUTER_X (RX),
    .ROUTER_Y (RY),
    .MAX_WAIT (MW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .vld_input_i   (vld),
    .dst_x_i       (dx),
    .dst_y_i       (dy),
    .full_i        (full),
    .wr_en_i       (wr),
    .mux_in_sel_o  (in_sel),
    .mux_out_sel_o (out_sel),
    .sel_vld_o     (sel_vld),
    .timeout_o     (tmo)
  );

  typedef struct packed {
    logic       v;
    logic [2:0] i;
    logic [2:0] o;
    logic       t;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   tmo_seen = 0;
  int   tmo_base = 0;

  bit   m_busy = 0;
  int   m_ptr = 0;
  int   m_in = 0;
  int   m_out = 0;
  int   m_busy_cycles = 0;
  exp_t m_last = '0;

  int tx[N];
  int ty[N];

  function automatic int route_of(input int x, input int y);
    if (x > RX) return 2;
    if (x < RX) return 4;
    if (y > RY) return 1;
    if (y < RY) return 3;
    return 0;
  endfunction

  task automatic chk(input bit ok, input string what);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s t=%0t v=%0b in=%0d out=%0d to=%0b", what, $time, sel_vld, in_sel,
               out_sel, tmo);
    end
  endtask

  task automatic cyc(input bit r, input logic [N-1:0] v, input logic [N-1:0] f,
                     input logic [N-1:0] w);
    exp_t e;
    @(negedge clk);
    #1;
    rst  = r;
    vld  = v;
    full = f;
    wr   = w;
    for (int p = 0; p < N; p++) begin
      dx[p*CW +: CW] = CW'(tx[p]);
      dy[p*CW +: CW] = CW'(ty[p]);
    end
    e = m_last;
    e.t = 1'b0;
    if (r) begin
      e      = '0;
      m_busy = 0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      e.v = 1'b0;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (!m_busy && v[p] && !f[route_of(tx[p], ty[p])]) begin
          m_busy        = 1;
          m_in          = p;
          m_out         = route_of(tx[p], ty[p]);
          m_busy_cycles = 0;
          e.v = 1'b1;
          e.i = 3'(m_in);
          e.o = 3'(m_out);
        end
      end
    end else begin
      m_busy_cycles++;
      if (w[m_out] || !v[m_in] || m_busy_cycles == MW) begin
        e.v    = 1'b0;
        e.t    = !w[m_out] && v[m_in];
        m_busy = 0;
        m_ptr  = (m_in + 1) % N;
      end else begin
        e.v = 1'b1;
      end
    end
    m_last = e;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (tmo === 1'b1) begin
      tmo_seen++;
    end
    if (sb.size() > 0) begin
      exp_t e;
      exp_t g;
      e = sb.pop_front();
      g = '{v: sel_vld, i: in_sel, o: out_sel, t: tmo};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL sched t=%0t got v=%0b in=%0d out=%0d to=%0b want v=%0b in=%0d out=%0d to=%0b",
                 $time, g.v, g.i, g.o, g.t, e.v, e.i, e.o, e.t);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    vld  = '0;
    full = '0;
    wr   = '0;
    dx   = '0;
    dy   = '0;
    for (int p = 0; p < N; p++) begin
      tx[p] = RX;
      ty[p] = RY;
    end

    repeat (3) cyc(1, '0, '0, '0);
    chk(sel_vld === 1'b0 && in_sel === 3'd0 && out_sel === 3'd0 && tmo === 1'b0,
        "reset_state");
    repeat (3) cyc(0, '0, '0, '0);

    tx[0] = 3; ty[0] = 1;
    cyc(0, 5'b00001, '0, '0);
    cyc(0, 5'b00001, '0, '0);
    cyc(0, 5'b00001, '0, 5'b00100);
    cyc(0, '0, '0, '0);

    tx[1] = 1; ty[1] = 1; tx[3] = 1; ty[3] = 1; tx[4] = 1; ty[4] = 1;
    repeat (8) cyc(0, 5'b11010, '0, 5'b00001);
    cyc(0, '0, '0, '0);

    tx[2] = 1; ty[2] = 0;
    repeat (4) cyc(0, 5'b00100, 5'b01000, '0);
    cyc(0, 5'b00100, '0, '0);
    cyc(0, 5'b00100, '0, 5'b01000);
    cyc(0, '0, '0, '0);

    tmo_base = tmo_seen;
    cyc(0, 5'b00100, '0, '0);
    repeat (18) cyc(0, 5'b00100, 5'b01000, '0);
    cyc(0, '0, '0, '0);
    @(negedge clk);
    chk(tmo_seen - tmo_base == 1 && sel_vld === 1'b0, "expired_wait");

    cyc(0, 5'b00100, '0, '0);
    cyc(0, 5'b00100, '0, '0);
    cyc(1, 5'b00100, '0, '0);
    cyc(0, 5'b10010, '0, '0);
    cyc(0, 5'b10010, '0, 5'b00001);
    cyc(0, '0, '0, '0);

    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 900; c++) begin
        logic [N-1:0] v, f, w;
        for (int p = 0; p < N; p++) begin
          if ($urandom_range(0, 7) == 0) begin
            tx[p] = int'($urandom_range(0, 3));
            ty[p] = int'($urandom_range(0, 3));
          end
          v[p] = ($urandom_range(0, 7) < (ph == 0 ? 5 : 7));
          f[p] = ($urandom_range(0, 7) < (ph == 0 ? 2 : 1));
          w[p] = (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
        end
        cyc($urandom_range(0, 199) == 0, v, f, w);
      end
    end

    cyc(0, '0, '0, '0);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
